// File: rtl/coin_acc_pkg.sv
// coin_acc_pkg: shared types and constants for the coin accumulator slice.
//   state_e   - transaction phase (IDLE / COLLECT / RESULT)
//   COINn_VAL - default credit in cents per denomination
//   MONEY_W   - width of money, price and refund values
package coin_acc_pkg;

    localparam int unsigned MONEY_W   = 13;
    localparam int unsigned MONEY_MAX = 8191;

    localparam int unsigned COIN0_VAL = 5;
    localparam int unsigned COIN1_VAL = 10;
    localparam int unsigned COIN2_VAL = 25;
    localparam int unsigned COIN3_VAL = 100;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        RESULT  = 2'd2
    } state_e;

endpackage : coin_acc_pkg

// File: rtl/coin_accumulator_if.sv
// coin_accumulator_if: payment-stage signal bundle.
//   Controller side drives: coin, collect_en, check, clear, price
//   Accumulator side drives: money, money_ok, refund, result_valid, overflow
//   modport slave  - used by coin_accumulator
//   modport master - used by the controller / testbench
interface coin_accumulator_if #(
    parameter int unsigned MONEY_W = coin_acc_pkg::MONEY_W
);
    logic [3:0]         coin;
    logic               collect_en;
    logic               check;
    logic               clear;
    logic [MONEY_W-1:0] price;
    logic [MONEY_W-1:0] money;
    logic               money_ok;
    logic [MONEY_W-1:0] refund;
    logic               result_valid;
    logic               overflow;

    modport slave (
        input  coin, collect_en, check, clear, price,
        output money, money_ok, refund, result_valid, overflow
    );

    modport master (
        output coin, collect_en, check, clear, price,
        input  money, money_ok, refund, result_valid, overflow
    );
endinterface : coin_accumulator_if

// File: rtl/rise_edge_detect.sv
// rise_edge_detect: per-bit rising-edge detector.
//   clk    - system clock
//   rst    - synchronous active-high reset
//   sig_i  - level inputs
//   rise_o - one-cycle pulse where sig_i went 0 -> 1
// History resets to all ones so a level already high through reset is not
// reported as an edge.
module rise_edge_detect #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sig_i,
    output logic [WIDTH-1:0] rise_o
);
    logic [WIDTH-1:0] hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '1;
        end else begin
            hist_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~hist_q;
endmodule : rise_edge_detect

// File: rtl/coin_accumulator.sv
// coin_accumulator: turns debounced coin levels into a running total and
// evaluates it against the selected price on request.
//   clk, reset        - clock and synchronous active-high reset
//   bus.coin          - coin button levels, one bit per denomination
//   bus.collect_en    - high while the controller is taking payment
//   bus.check         - evaluation strobe (sampled price)
//   bus.clear         - end-of-transaction strobe
//   bus.money         - running total (saturating)
//   bus.money_ok      - total covered the price at evaluation
//   bus.refund        - change, or full return on shortfall/abort
//   bus.result_valid  - money_ok/refund are valid
//   bus.overflow      - sticky saturation flag for this transaction
module coin_accumulator
    import coin_acc_pkg::*;
#(
    parameter int unsigned COIN0_VAL = coin_acc_pkg::COIN0_VAL,
    parameter int unsigned COIN1_VAL = coin_acc_pkg::COIN1_VAL,
    parameter int unsigned COIN2_VAL = coin_acc_pkg::COIN2_VAL,
    parameter int unsigned COIN3_VAL = coin_acc_pkg::COIN3_VAL,
    parameter int unsigned MONEY_W   = coin_acc_pkg::MONEY_W,
    parameter int unsigned MONEY_MAX = coin_acc_pkg::MONEY_MAX
) (
    input  logic               clk,
    input  logic               reset,
    coin_accumulator_if.slave  bus
);
    localparam int unsigned SUM_W = MONEY_W + 2;

    state_e             state_q, state_d;
    logic [MONEY_W-1:0] money_q, money_d;
    logic [MONEY_W-1:0] refund_q, refund_d;
    logic               ok_q, ok_d;
    logic               valid_q, valid_d;
    logic               ovf_q, ovf_d;

    logic [3:0]         rise;
    logic [SUM_W-1:0]   credit;
    logic [SUM_W-1:0]   sum;
    logic               sat;
    logic [MONEY_W-1:0] sum_sat;
    logic               covers;

    rise_edge_detect #(
        .WIDTH (4)
    ) u_edge (
        .clk    (clk),
        .rst    (reset),
        .sig_i  (bus.coin),
        .rise_o (rise)
    );

    // All simultaneous edges are credited; widened so the clamp sees the true sum.
    always_comb begin
        credit = '0;
        if (rise[0]) credit = credit + SUM_W'(COIN0_VAL);
        if (rise[1]) credit = credit + SUM_W'(COIN1_VAL);
        if (rise[2]) credit = credit + SUM_W'(COIN2_VAL);
        if (rise[3]) credit = credit + SUM_W'(COIN3_VAL);
        sum     = SUM_W'(money_q) + credit;
        sat     = (sum > SUM_W'(MONEY_MAX));
        sum_sat = sat ? MONEY_W'(MONEY_MAX) : sum[MONEY_W-1:0];
        covers  = (sum_sat >= bus.price);
    end

    always_comb begin
        state_d  = state_q;
        money_d  = money_q;
        refund_d = refund_q;
        ok_d     = ok_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;

        if (bus.clear) begin
            state_d  = IDLE;
            money_d  = '0;
            refund_d = '0;
            ok_d     = 1'b0;
            valid_d  = 1'b0;
            ovf_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    money_d = '0;
                    if (bus.collect_en) state_d = COLLECT;
                end
                COLLECT: begin
                    money_d = sum_sat;
                    if (sat) ovf_d = 1'b1;
                    // check takes precedence over a simultaneous collect_en drop
                    if (bus.check) begin
                        ok_d     = covers;
                        refund_d = covers ? (sum_sat - bus.price) : sum_sat;
                        valid_d  = 1'b1;
                        state_d  = RESULT;
                    end else if (!bus.collect_en) begin
                        ok_d     = 1'b0;
                        refund_d = money_q;
                        valid_d  = 1'b1;
                        state_d  = RESULT;
                    end
                end
                RESULT: begin
                    state_d = RESULT;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            money_q  <= '0;
            refund_q <= '0;
            ok_q     <= 1'b0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            money_q  <= money_d;
            refund_q <= refund_d;
            ok_q     <= ok_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.money        = money_q;
    assign bus.refund       = refund_q;
    assign bus.money_ok     = ok_q;
    assign bus.result_valid = valid_q;
    assign bus.overflow     = ovf_q;
endmodule : coin_accumulator

// File: tb/tb_coin_accumulator.sv
module tb_coin_accumulator;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    bit   cmp_en;

    coin_accumulator_if #(.MONEY_W(13)) bus ();

    coin_accumulator dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: phase 0 = waiting, 1 = taking coins, 2 = answer shown.
    int         m_phase;
    int         m_money;
    int         m_refund;
    int         m_ok;
    int         m_valid;
    int         m_ovf;
    logic [3:0] m_hist;

    always @(posedge clk) begin
        int ph, mn, rf, ok, vl, ov, tot, cr;
        logic [3:0] rs;
        ph = m_phase; mn = m_money; rf = m_refund; ok = m_ok; vl = m_valid; ov = m_ovf;
        if (rst) begin
            ph = 0; mn = 0; rf = 0; ok = 0; vl = 0; ov = 0;
            m_hist <= 4'hF;
        end else begin
            rs = bus.coin & ~m_hist;
            m_hist <= bus.coin;
            cr = (rs[0] ? 5 : 0) + (rs[1] ? 10 : 0) + (rs[2] ? 25 : 0) + (rs[3] ? 100 : 0);
            if (bus.clear) begin
                ph = 0; mn = 0; rf = 0; ok = 0; vl = 0; ov = 0;
            end else if (ph == 0) begin
                mn = 0;
                if (bus.collect_en) ph = 1;
            end else if (ph == 1) begin
                tot = m_money + cr;
                if (tot > 8191) begin
                    tot = 8191;
                    ov = 1;
                end
                mn = tot;
                if (bus.check) begin
                    ok = (tot >= int'(bus.price)) ? 1 : 0;
                    rf = (ok != 0) ? tot - int'(bus.price) : tot;
                    vl = 1;
                    ph = 2;
                end else if (!bus.collect_en) begin
                    ok = 0;
                    rf = m_money;
                    vl = 1;
                    ph = 2;
                end
            end
        end
        m_phase <= ph; m_money <= mn; m_refund <= rf;
        m_ok <= ok; m_valid <= vl; m_ovf <= ov;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("money",        int'(bus.money),        m_money);
            chk("refund",       int'(bus.refund),       m_refund);
            chk("money_ok",     int'(bus.money_ok),     m_ok);
            chk("result_valid", int'(bus.result_valid), m_valid);
            chk("overflow",     int'(bus.overflow),     m_ovf);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int idx);
        bus.coin[idx] = 1'b1;
        tick();
        bus.coin[idx] = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // clear any leftover transaction, then enter COLLECT
    task automatic start();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.collect_en = 1'b1;
        tick();
    endtask

    task automatic evaluate(input int p);
        bus.price = 13'(p);
        bus.check = 1'b1;
        tick();
        bus.check = 1'b0;
    endtask

    task automatic lit(input string name, input int act, input int exp, input int model);
        chk(name, act, exp);
        chk({name, "_model"}, model, exp);
    endtask

    initial begin
        total = 0; bad = 0; cmp_en = 1'b0;
        rst = 1'b1;
        bus.coin = '0; bus.collect_en = 1'b0; bus.check = 1'b0;
        bus.clear = 1'b0; bus.price = '0;

        // 1: 10+10+100, price 100
        do_reset();
        cmp_en = 1'b1;
        lit("rst_money", int'(bus.money), 0, m_money);
        lit("rst_valid", int'(bus.result_valid), 0, m_valid);
        bus.collect_en = 1'b1;
        tick();
        press(1); press(1); press(3);
        lit("t1_money_pre", int'(bus.money), 120, m_money);
        evaluate(100);
        lit("t1_valid", int'(bus.result_valid), 1, m_valid);
        lit("t1_ok", int'(bus.money_ok), 1, m_ok);
        lit("t1_refund", int'(bus.refund), 20, m_refund);

        // 2: 25 against 100, then clear
        start();
        press(2);
        evaluate(100);
        lit("t2_ok", int'(bus.money_ok), 0, m_ok);
        lit("t2_refund", int'(bus.refund), 25, m_refund);
        bus.collect_en = 1'b0;
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        lit("t2_clr_money", int'(bus.money), 0, m_money);
        lit("t2_clr_valid", int'(bus.result_valid), 0, m_valid);
        lit("t2_clr_refund", int'(bus.refund), 0, m_refund);

        // 3: simultaneous edges plus an edge in the check cycle
        start();
        bus.coin = 4'b0101;
        tick();
        bus.coin = 4'b0000;
        tick();
        bus.coin = 4'b1000;
        evaluate(130);
        bus.coin = 4'b0000;
        lit("t3_money", int'(bus.money), 130, m_money);
        lit("t3_ok", int'(bus.money_ok), 1, m_ok);
        lit("t3_refund", int'(bus.refund), 0, m_refund);

        // 4: saturation
        start();
        for (int i = 0; i < 82; i++) press(3);
        lit("t4_sat", int'(bus.money), 8191, m_money);
        for (int i = 0; i < 10; i++) press(3);
        evaluate(8000);
        lit("t4_money", int'(bus.money), 8191, m_money);
        lit("t4_ovf", int'(bus.overflow), 1, m_ovf);
        lit("t4_ok", int'(bus.money_ok), 1, m_ok);
        lit("t4_refund", int'(bus.refund), 191, m_refund);

        // 5: button held through reset, then abort
        bus.coin = 4'b1000;
        bus.collect_en = 1'b0;
        do_reset();
        bus.collect_en = 1'b1;
        tick(); tick(); tick();
        lit("t5_held", int'(bus.money), 0, m_money);
        bus.coin = 4'b0000;
        tick();
        press(3);
        lit("t5_money", int'(bus.money), 100, m_money);
        bus.collect_en = 1'b0;
        tick();
        lit("t5_valid", int'(bus.result_valid), 1, m_valid);
        lit("t5_ok", int'(bus.money_ok), 0, m_ok);
        lit("t5_refund", int'(bus.refund), 100, m_refund);

        // 6: reset mid-collect, then check in IDLE
        start();
        press(2); press(1);
        lit("t6_pre", int'(bus.money), 35, m_money);
        bus.collect_en = 1'b0;
        do_reset();
        lit("t6_money", int'(bus.money), 0, m_money);
        evaluate(0);
        lit("t6_idle_valid", int'(bus.result_valid), 0, m_valid);
        lit("t6_idle_ok", int'(bus.money_ok), 0, m_ok);

        // random traffic, checked every cycle against the model
        for (int i = 0; i < 4000; i++) begin
            rst            = ($urandom_range(0, 299) == 0);
            bus.clear      = ($urandom_range(0, 39) == 0);
            bus.check      = ($urandom_range(0, 19) == 0);
            bus.collect_en = ($urandom_range(0, 29) != 0);
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 2) == 0) bus.coin[b] = ~bus.coin[b];
            bus.price = ($urandom_range(0, 9) == 0) ? 13'd0 : 13'($urandom_range(0, 400));
            tick();
        end
        rst = 1'b0; bus.clear = 1'b0; bus.check = 1'b0;
        tick();
        cmp_en = 1'b0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule : tb_coin_accumulator

// File: doc/coin_accumulator.md
Name: coin_accumulator

Overview:
- Payment-collection stage directly upstream of the vending controller FSM.
- Converts debounced coin-button levels into a running money total and compares it against the selected price on request.
- Drives the controller's money_checker input, plus the money and refund values consumed by the display path.

Parameters:
- COIN0_VAL, 5, value in cents credited per rising edge of coin[0]
- COIN1_VAL, 10, value per rising edge of coin[1]
- COIN2_VAL, 25, value per rising edge of coin[2]
- COIN3_VAL, 100, value per rising edge of coin[3]
- MONEY_W, 13, width of money, price and refund
- MONEY_MAX, 8191, saturation ceiling (must be <= 2^MONEY_W-1)

Ports:
- clk  in  1  system clock; one clock domain; reset is synchronous and active-high
- reset  in  1  synchronous active-high reset
- coin  in  4  debounced coin-button levels, one bit per denomination
- collect_en  in  1  high while the controller is in its payment state
- check  in  1  one-cycle strobe requesting evaluation
- clear  in  1  one-cycle strobe ending the transaction
- price  in  MONEY_W  price of the selected item, sampled on check
- money  out  MONEY_W  running total inserted
- money_ok  out  1  money >= price at evaluation; feeds money_checker
- refund  out  MONEY_W  change or full return amount
- result_valid  out  1  money_ok and refund are valid
- overflow  out  1  sticky; the total saturated during this transaction

Behaviour:
- States: IDLE, COLLECT, RESULT. Encoding comes from the shared package.
- Reset value of every output is 0; state goes to IDLE; the edge-detect history register goes to 4'b1111.
  - Because history resets to all ones, buttons held through reset are not credited.
- Priority each cycle: reset > clear > state logic.
- clear in any state: next cycle is IDLE with money, refund, money_ok, result_valid and overflow all 0.
- Edge detect runs every cycle: rise[i] = coin[i] & ~hist[i]; then hist <= coin.
  - Edges are credited only in COLLECT.
  - A button already high when entering COLLECT is not credited until it is released and pressed again.
- IDLE: money held at 0. When collect_en=1, go to COLLECT on the next cycle.
- COLLECT:
  - sum = money + sum of COINi_VAL over all i with rise[i]=1. Several simultaneous edges all count.
  - If sum > MONEY_MAX: money <= MONEY_MAX and overflow <= 1. Compute sum at MONEY_W+2 bits before clamping.
  - Otherwise money <= sum.
- check=1 in COLLECT:
  - Comparison uses the updated sum, so edges in the check cycle are counted.
  - money_ok <= (sum_sat >= price).
  - refund <= money_ok ? sum_sat - price : sum_sat.
  - result_valid <= 1; go to RESULT. Latency: outputs are valid 1 cycle after check.
- collect_en falls in COLLECT without check (abort):
  - money_ok <= 0, refund <= money, result_valid <= 1; go to RESULT.
- check and collect_en=0 in the same cycle: check wins and a normal evaluation occurs.
- price = 0: money_ok = 1 and refund = money.
- RESULT:
  - All outputs hold; coin edges, check and collect_en are ignored.
  - Leave only via clear or reset.
- check outside COLLECT is ignored.
- Reset mid-transaction drops all credit; there is no refund.
- Unsigned arithmetic throughout; subtraction happens only when money >= price, so it never underflows.

Decomposition:
- Package coin_acc_pkg:
  - state enum IDLE/COLLECT/RESULT
  - default coin value constants
  - MONEY_W
- Sub-module rise_edge_detect (parameter WIDTH=4, reset history to all ones), instantiated once for coin.
- Accumulator, saturation and FSM stay in the top block.

Test Plan:
1. Reset, collect_en=1, coin[1] pulses twice, coin[3] once, price=100, check -> money=120, money_ok=1, refund=20, result_valid high 1 cycle after check.
2. Insert 25 with price=100, then check -> money_ok=0, refund=25; clear -> all outputs 0 next cycle, state IDLE.
3. coin[0] and coin[2] rise in the same cycle, and coin[3] rises in the check cycle, price=130 -> money=130, money_ok=1, refund=0.
4. Press coin[3] 82 times, then 10 more, then check with price=8000 -> money=8191 after saturation, overflow=1, money_ok=1, refund=191.
5. Hold coin[3] high through reset and entry to COLLECT -> no credit; release, press again -> money=100. Then drop collect_en without check -> money_ok=0, refund=100.
6. Assert reset mid-COLLECT with money=35 -> all outputs 0 next cycle, state IDLE; a check in IDLE has no effect.
